// File: rtl/fifo_rd_unpack.sv
// Read-side unpacker for a show-ahead FIFO. Pops DATASIZE-bit words and
// serialises each one into RATIO = DATASIZE/OUTW beats on a valid/ready
// stream, least-significant beat first. A pop counter tracks consumed words.
//
// Ports:
//   rclk      - read-domain clock
//   rst       - synchronous active-high reset
//   rdata     - FIFO head word, valid while rempty_n is high
//   rempty_n  - FIFO not-empty flag
//   rinc      - FIFO pop strobe (head advances on the edge where it is high)
//   out_data  - current beat
//   out_valid - beat valid
//   out_last  - final beat of a word
//   out_ready - downstream accepts a beat on out_valid & out_ready
//   word_cnt  - words popped since reset, wrapping
module fifo_rd_unpack #(
  parameter int unsigned DATASIZE = 40,
  parameter int unsigned OUTW     = 10
) (
  input  logic                rclk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                rempty_n,
  output logic                rinc,
  output logic [OUTW-1:0]     out_data,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  output logic [15:0]         word_cnt
);

  localparam int unsigned RATIO = DATASIZE / OUTW;
  localparam int unsigned IdxW  = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {StEmpty, StBusy} state_e;

  state_e              state_q, state_d;
  logic [DATASIZE-1:0] hold_q, hold_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [15:0]         word_cnt_q, word_cnt_d;

  logic busy;
  logic at_last;
  logic [OUTW-1:0] beat;

  assign busy    = (state_q == StBusy);
  assign at_last = (idx_q == IdxW'(RATIO - 1));

  // Pop from EMPTY unconditionally, or as the last beat is accepted so the
  // next word follows with no bubble.
  assign rinc = ~rst & rempty_n & (~busy | (out_ready & at_last));

  // State register
  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q    <= StEmpty;
      hold_q     <= '0;
      idx_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    word_cnt_d = word_cnt_q + {15'd0, rinc};
    unique case (state_q)
      StEmpty: begin
        if (rinc) begin
          hold_d  = rdata;
          idx_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (out_ready) begin
          if (!at_last) begin
            idx_d = idx_q + 1'b1;
          end else if (rinc) begin
            hold_d = rdata;
            idx_d  = '0;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Beat select without a variable-width multiply on the index
  always_comb begin
    beat = '0;
    for (int unsigned b = 0; b < RATIO; b++) begin
      if (idx_q == IdxW'(b)) begin
        beat = hold_q[b*OUTW +: OUTW];
      end
    end
  end

  // Outputs; gated by rst so nothing leaks out before the first reset edge
  always_comb begin
    out_valid = busy & ~rst;
    out_last  = busy & ~rst & at_last;
    out_data  = (busy & ~rst) ? beat : '0;
    word_cnt  = word_cnt_q;
  end

endmodule

// File: tb/tb_fifo_rd_unpack.sv
module tb_fifo_rd_unpack;

  logic        rclk;
  logic        rst;
  logic [39:0] rdata;
  logic        rempty_n;
  logic        rinc;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO contents as seen by the DUT (head at index 0)
  logic [39:0] fifo_q[$];

  // Outputs captured on the falling edge of the most recent step
  logic        s_valid, s_last, s_rinc;
  logic [9:0]  s_data;
  logic [15:0] s_cnt;

  fifo_rd_unpack #(
    .DATASIZE(40),
    .OUTW    (10)
  ) dut (
    .rclk     (rclk),
    .rst      (rst),
    .rdata    (rdata),
    .rempty_n (rempty_n),
    .rinc     (rinc),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready),
    .word_cnt (word_cnt)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic refresh();
    rempty_n = (fifo_q.size() != 0);
    rdata    = (fifo_q.size() != 0) ? fifo_q[0] : 40'h0;
  endtask

  // One clock: sample outputs mid-cycle, then apply the pop at the edge
  task automatic step();
    @(negedge rclk);
    s_valid = out_valid;
    s_last  = out_last;
    s_data  = out_data;
    s_rinc  = rinc;
    s_cnt   = word_cnt;
    @(posedge rclk);
    if (s_rinc && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #1 refresh();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    fifo_q.push_back(40'h123456789A);
    refresh();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (s_rinc !== 1'b0 || s_valid !== 1'b0 || s_cnt !== 16'h0) begin
        n_fail++;
        $display("FAIL reset[%0d]: rinc=%b valid=%b cnt=%h, required 0 0 0000",
                 i, s_rinc, s_valid, s_cnt);
      end
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (s_rinc !== 1'b1 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_pop: rinc=%b valid=%b, required 1 0", s_rinc, s_valid);
    end
  endtask

  task automatic test_single();
    logic [9:0] exp[4];
    exp[0] = 10'h09A; exp[1] = 10'h19E; exp[2] = 10'h345; exp[3] = 10'h048;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== exp[k] || s_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL single_beat[%0d]: valid=%b data=%h last=%b, required 1 %h %b",
                 k, s_valid, s_data, s_last, exp[k], (k == 3));
      end
    end
    step();
    n_checks++;
    if (s_valid !== 1'b0 || s_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL single_end: valid=%b cnt=%h, required 0 0001", s_valid, s_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp[12];
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < 4; b++) exp[w*4+b] = 10'(10'h300 + w*16 + b);
      fifo_q.push_back({exp[w*4+3], exp[w*4+2], exp[w*4+1], exp[w*4]});
    end
    refresh();
    step();
    n_checks++;
    if (s_rinc !== 1'b1 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first_pop: rinc=%b valid=%b, required 1 0", s_rinc, s_valid);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== exp[k] || s_last !== (k % 4 == 3) ||
          s_rinc !== (k == 3 || k == 7)) begin
        n_fail++;
        $display("FAIL b2b_beat[%0d]: valid=%b data=%h last=%b rinc=%b, required 1 %h %b %b",
                 k, s_valid, s_data, s_last, s_rinc, exp[k], (k % 4 == 3),
                 (k == 3 || k == 7));
      end
    end
    step();
    n_checks++;
    if (s_valid !== 1'b0 || s_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL b2b_end: valid=%b cnt=%h, required 0 0004", s_valid, s_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp[8];
    logic       pat[13];
    int         n;
    exp[0] = 10'h111; exp[1] = 10'h222; exp[2] = 10'h333; exp[3] = 10'h044;
    exp[4] = 10'h155; exp[5] = 10'h266; exp[6] = 10'h377; exp[7] = 10'h088;
    pat = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1, 1};
    fifo_q.push_back({exp[3], exp[2], exp[1], exp[0]});
    fifo_q.push_back({exp[7], exp[6], exp[5], exp[4]});
    refresh();
    out_ready = 1'b0;
    step();
    n = 0;
    for (int i = 0; i < 13; i++) begin
      out_ready = pat[i];
      step();
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== exp[n] || s_last !== (n % 4 == 3) ||
          s_rinc !== (pat[i] && n == 3)) begin
        n_fail++;
        $display("FAIL bp_cycle[%0d]: valid=%b data=%h last=%b rinc=%b, required 1 %h %b %b",
                 i, s_valid, s_data, s_last, s_rinc, exp[n], (n % 4 == 3),
                 (pat[i] && n == 3));
      end
      if (pat[i]) n++;
    end
    step();
    n_checks++;
    if (s_valid !== 1'b0 || s_cnt !== 16'd6) begin
      n_fail++;
      $display("FAIL bp_end: valid=%b cnt=%h, required 0 0006", s_valid, s_cnt);
    end
  endtask

  task automatic test_mid_reset();
    logic [9:0] exp[4];
    exp[0] = 10'h001; exp[1] = 10'h002; exp[2] = 10'h003; exp[3] = 10'h004;
    out_ready = 1'b1;
    fifo_q.push_back(40'hFFFFFFFFFF);
    fifo_q.push_back({exp[3], exp[2], exp[1], exp[0]});
    refresh();
    step();
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== 10'h3FF) begin
        n_fail++;
        $display("FAIL mid_pre[%0d]: valid=%b data=%h, required 1 3ff", k, s_valid, s_data);
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (s_valid !== 1'b0 || s_cnt !== 16'd0 || s_rinc !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_after_reset: valid=%b cnt=%h rinc=%b, required 0 0000 1",
               s_valid, s_cnt, s_rinc);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (s_valid !== 1'b1 || s_data !== exp[k]) begin
        n_fail++;
        $display("FAIL mid_next_word[%0d]: valid=%b data=%h, required 1 %h",
                 k, s_valid, s_data, exp[k]);
      end
    end
    step();
  endtask

  task automatic test_wrap();
    force dut.word_cnt_q = 16'hFFFE;
    #1 release dut.word_cnt_q;
    fifo_q.push_back(40'h0);
    fifo_q.push_back(40'h0);
    refresh();
    out_ready = 1'b1;
    step();
    n_checks++;
    if (s_cnt !== 16'hFFFE || s_rinc !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_preload: cnt=%h rinc=%b, required fffe 1", s_cnt, s_rinc);
    end
    step();
    n_checks++;
    if (s_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_ffff: cnt=%h, required ffff", s_cnt);
    end
    step(); step(); step();
    step();
    n_checks++;
    if (s_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_zero: cnt=%h, required 0000", s_cnt);
    end
    for (int k = 0; k < 4; k++) step();
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    refresh();
    @(posedge rclk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
